// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, the 12-bit colour type,
// colour-bar constants used by the test pattern and the sprite modules.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned CNT_W = 10;

  typedef logic [11:0] color_t;

  localparam color_t COLOR_WHITE   = 12'hFFF;
  localparam color_t COLOR_YELLOW  = 12'hFF0;
  localparam color_t COLOR_CYAN    = 12'h0FF;
  localparam color_t COLOR_GREEN   = 12'h0F0;
  localparam color_t COLOR_MAGENTA = 12'hF0F;
  localparam color_t COLOR_RED     = 12'hF00;
  localparam color_t COLOR_BLUE    = 12'h00F;
  localparam color_t COLOR_BLACK   = 12'h000;

  // Active-high internal flags carried down the delay line
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } vflags_t;

  // Eight 80-pixel vertical bars across the visible line
  function automatic color_t bar_color(input logic [CNT_W-1:0] col);
    color_t c;
    if      (col < 10'd80)  c = COLOR_WHITE;
    else if (col < 10'd160) c = COLOR_YELLOW;
    else if (col < 10'd240) c = COLOR_CYAN;
    else if (col < 10'd320) c = COLOR_GREEN;
    else if (col < 10'd400) c = COLOR_MAGENTA;
    else if (col < 10'd480) c = COLOR_RED;
    else if (col < 10'd560) c = COLOR_BLUE;
    else                    c = COLOR_BLACK;
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel divider, horizontal/vertical scan counters, raw (undelayed)
// active/sync flags and the registered frame_start pulse.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CLK_DIV  = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             video_on,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             frame_start
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;

  assign pix_tick = (div_cnt_q == DIV_LAST);

  // Next-state for divider and scan counters; frame_start fires as (0,0) loads
  always_comb begin
    div_cnt_d     = div_cnt_q + 1'b1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_tick) begin
      div_cnt_d = '0;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign frame_start = frame_start_q;
  assign video_on    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign hsync_act   = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vsync_act   = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and registered pixel output stage.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned SYNC_POL   = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] pix_row,
  output logic [CNT_W-1:0] pix_col,
  output logic             video_on,
  output logic             pix_tick,
  output logic             frame_start,
  input  logic             pattern_en,
  input  logic [11:0]      color_in,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync
);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic    hsync_act, vsync_act;
  vflags_t flags_now;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_sync_counter (
    .clk         (clk),
    .reset       (reset),
    .pix_tick    (pix_tick),
    .h_cnt       (pix_col),
    .v_cnt       (pix_row),
    .video_on    (video_on),
    .hsync_act   (hsync_act),
    .vsync_act   (vsync_act),
    .frame_start (frame_start)
  );

  assign flags_now = '{video_on: video_on, hsync: hsync_act, vsync: vsync_act};

  // The pattern build also carries the column so bars line up with the delayed flags
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned TAP_W = 3 + CNT_W;
  logic [TAP_W-1:0] tap_now;
  assign tap_now = {flags_now, pix_col};
`else
  localparam int unsigned TAP_W = 3;
  logic [TAP_W-1:0] tap_now;
  assign tap_now = flags_now;
`endif

  logic [TAP_W-1:0] tap_out;

  if (PIPE_DELAY > 1) begin : g_dly
    logic [TAP_W-1:0] dly_q [PIPE_DELAY-1];
    logic [TAP_W-1:0] dly_d [PIPE_DELAY-1];

    // Shift the flag delay line one stage per pixel tick
    always_comb begin
      dly_d = dly_q;
      if (pix_tick) begin
        dly_d[0] = tap_now;
        for (int unsigned i = 1; i < PIPE_DELAY - 1; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    // Delay stages clear to inactive so no sync pulse survives a reset
    always_ff @(posedge clk) begin
      if (reset) dly_q <= '{default: '0};
      else       dly_q <= dly_d;
    end

    assign tap_out = dly_q[PIPE_DELAY-2];
  end else begin : g_nodly
    assign tap_out = tap_now;
  end

  vflags_t flags_tap;
  color_t  color_sel;
  assign flags_tap = tap_out[TAP_W-1 -: 3];

`ifdef VGA_TEST_PATTERN_EN
  assign color_sel = pattern_en ? bar_color(tap_out[CNT_W-1:0]) : color_in;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
  assign color_sel         = color_in;
`endif

  color_t rgb_q, rgb_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  // Output stage: blank outside the active area, apply sync polarity
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_tick) begin
      rgb_d   = flags_tap.video_on ? color_sel : '0;
      hsync_d = flags_tap.hsync ~^ SYNC_ACT;
      vsync_d = flags_tap.vsync ~^ SYNC_ACT;
    end
  end

  // Output registers, reset to black and inactive sync
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga_r     = rgb_q[11:8];
  assign vga_g     = rgb_q[7:4];
  assign vga_b     = rgb_q[3:0];
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;

endmodule
